// File: rtl/mem_read_b_if.sv
// mem_read_b_if: request side (start, sizes, ready) and per-bank read-issue
// side (addresses, enables, valid/k flags, busy/done) of mem_read_b.
interface mem_read_b_if #(
  parameter int N2           = 4,
  parameter int MATRIXSIZE_W = 16,
  parameter int ADDR_W       = 12
) ();
  logic                    start;
  logic [MATRIXSIZE_W-1:0] m1dn1;
  logic [MATRIXSIZE_W-1:0] m2;
  logic [MATRIXSIZE_W-1:0] m3dn2;
  logic                    ready;
  logic [N2*ADDR_W-1:0]    rd_addr_b;
  logic [N2-1:0]           rd_en_b;
  logic                    valid_out;
  logic                    first_k;
  logic                    last_k;
  logic                    busy;
  logic                    done;

  modport master (
    output start, m1dn1, m2, m3dn2, ready,
    input  rd_addr_b, rd_en_b, valid_out, first_k, last_k, busy, done
  );

  modport slave (
    input  start, m1dn1, m2, m3dn2, ready,
    output rd_addr_b, rd_en_b, valid_out, first_k, last_k, busy, done
  );
endinterface

// File: rtl/mem_read_b.sv
// mem_read_b: streams matrix B out of N2 banks, replaying the whole matrix
// once per A row-block. Address is col_base + k, where col_base steps by M2
// on each column-block wrap and clears on each row-block wrap.
// Optional macro MEM_READ_B_SKEW_EN: lane j of rd_en_b/rd_addr_b is lane 0
// delayed by j cycles (systolic input skew); done waits for the last lane.
//
// state | meaning
// IDLE  | waiting for start; sizes latched on start
// RUN   | issuing one address per cycle while ready is high
// DRAIN | no more issues; waiting for in-flight reads to retire
module mem_read_b #(
  parameter int N2           = 4,
  parameter int MATRIXSIZE_W = 16,
  parameter int ADDR_W       = 12,
  parameter int RD_LAT       = 1
) (
  input logic         clk,
  input logic         rst,
  mem_read_b_if.slave bus
);
  localparam int MW = MATRIXSIZE_W;
  // every pipeline stage except the final output stage
  localparam logic [RD_LAT-1:0] TAIL_MASK = RD_LAT'((1 << (RD_LAT - 1)) - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  state_t state, state_nxt;

  logic [MW-1:0]     m1_q, m2_q, m3_q;
  logic [MW-1:0]     k_cnt, p_cnt, i_cnt, col_base;
  logic [MW-1:0]     addr_sum;
  logic              issue, k_wrap, p_wrap, i_wrap, size_zero, drain_empty;
  logic              en0, first0, last0, done_q;
  logic [ADDR_W-1:0] addr0;
  logic [RD_LAT-1:0] v_pipe, f_pipe, l_pipe;

  assign k_wrap    = (k_cnt == m2_q - MW'(1));
  assign p_wrap    = (p_cnt == m3_q - MW'(1));
  assign i_wrap    = (i_cnt == m1_q - MW'(1));
  assign size_zero = (bus.m1dn1 == '0) || (bus.m2 == '0) || (bus.m3dn2 == '0);
  assign addr_sum  = col_base + k_cnt;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state and issue decision
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:    if (bus.start) state_nxt = size_zero ? DRAIN : RUN;
      RUN: begin
        if (bus.ready) begin
          issue = 1'b1;
          if (k_wrap && p_wrap && i_wrap) state_nxt = DRAIN;
        end
      end
      DRAIN:   if (drain_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // size latch and k/p/i loop counters with column-base accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      m1_q     <= '0;
      m2_q     <= '0;
      m3_q     <= '0;
      k_cnt    <= '0;
      p_cnt    <= '0;
      i_cnt    <= '0;
      col_base <= '0;
    end else if (state == IDLE && bus.start) begin
      m1_q     <= bus.m1dn1;
      m2_q     <= bus.m2;
      m3_q     <= bus.m3dn2;
      k_cnt    <= '0;
      p_cnt    <= '0;
      i_cnt    <= '0;
      col_base <= '0;
    end else if (issue) begin
      if (k_wrap) begin
        k_cnt <= '0;
        if (p_wrap) begin
          p_cnt    <= '0;
          col_base <= '0;
          i_cnt    <= i_wrap ? '0 : i_cnt + MW'(1);
        end else begin
          p_cnt    <= p_cnt + MW'(1);
          col_base <= col_base + m2_q;
        end
      end else begin
        k_cnt <= k_cnt + MW'(1);
      end
    end
  end

  // registered lane-0 issue, read-latency pipeline and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      en0    <= 1'b0;
      first0 <= 1'b0;
      last0  <= 1'b0;
      addr0  <= '0;
      v_pipe <= '0;
      f_pipe <= '0;
      l_pipe <= '0;
      done_q <= 1'b0;
    end else begin
      en0    <= issue;
      first0 <= issue && (k_cnt == '0);
      last0  <= issue && k_wrap;
      if (issue) addr0 <= ADDR_W'(addr_sum);
      v_pipe[0] <= en0;
      f_pipe[0] <= first0;
      l_pipe[0] <= last0;
      for (int s = 1; s < RD_LAT; s++) begin
        v_pipe[s] <= v_pipe[s-1];
        f_pipe[s] <= f_pipe[s-1];
        l_pipe[s] <= l_pipe[s-1];
      end
      done_q <= (state == DRAIN) && drain_empty;
    end
  end

`ifdef MEM_READ_B_SKEW_EN
  logic [N2-1:1]     sk_en;
  logic [ADDR_W-1:0] sk_addr [1:N2-1];
  logic [RD_LAT-1:0] ret_pipe;

  // lane j trails lane 0 by j cycles; ret_pipe tracks the last lane's data return
  always_ff @(posedge clk) begin
    if (rst) begin
      sk_en    <= '0;
      ret_pipe <= '0;
      for (int j = 1; j < N2; j++) sk_addr[j] <= '0;
    end else begin
      sk_en[1]   <= en0;
      sk_addr[1] <= addr0;
      for (int j = 2; j < N2; j++) begin
        sk_en[j]   <= sk_en[j-1];
        sk_addr[j] <= sk_addr[j-1];
      end
      ret_pipe[0] <= sk_en[N2-1];
      for (int s = 1; s < RD_LAT; s++) ret_pipe[s] <= ret_pipe[s-1];
    end
  end

  assign drain_empty = !en0 && (sk_en == '0) && ((ret_pipe & TAIL_MASK) == '0);

  // per-lane outputs from the skew chain
  always_comb begin
    bus.rd_en_b                = {sk_en, en0};
    bus.rd_addr_b              = '0;
    bus.rd_addr_b[0 +: ADDR_W] = addr0;
    for (int j = 1; j < N2; j++) bus.rd_addr_b[j*ADDR_W +: ADDR_W] = sk_addr[j];
  end
`else
  assign drain_empty = !en0 && ((v_pipe & TAIL_MASK) == '0);

  // all lanes share lane 0
  always_comb begin
    bus.rd_en_b   = {N2{en0}};
    bus.rd_addr_b = {N2{addr0}};
  end
`endif

  assign bus.valid_out = v_pipe[RD_LAT-1];
  assign bus.first_k   = f_pipe[RD_LAT-1];
  assign bus.last_k    = l_pipe[RD_LAT-1];
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mem_read_b.sv
// tb_mem_read_b: directed passes with a scoreboard; expected read beats are
// queued when a pass is launched and a negedge monitor pops them as the DUT
// presents rd_en_b[0] / valid_out.
module tb_mem_read_b;
  localparam int N2 = 4;
  localparam int MW = 16;
  localparam int AW = 12;
  localparam int RL = 1;
`ifdef MEM_READ_B_SKEW_EN
  localparam int OFF = N2 - 1;
`else
  localparam int OFF = 0;
`endif
  localparam logic [N2-1:0] ALL_EN = '1;

  typedef struct {
    int addr;
    bit first;
    bit last;
  } beat_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   first_en_cyc = -1;
  int   last_v_cyc = -1;
  beat_t exp_rd[$];
  beat_t exp_v[$];

  mem_read_b_if #(.N2(N2), .MATRIXSIZE_W(MW), .ADDR_W(AW)) bus ();

  mem_read_b #(.N2(N2), .MATRIXSIZE_W(MW), .ADDR_W(AW), .RD_LAT(RL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_beat(input int addr, input bit first, input bit last, input bit to_v);
    beat_t b;
    b.addr  = addr;
    b.first = first;
    b.last  = last;
    exp_rd.push_back(b);
    if (to_v) exp_v.push_back(b);
  endtask

  task automatic push_pass(input int m1, input int m2, input int m3);
    for (int i = 0; i < m1; i++)
      for (int p = 0; p < m3; p++)
        for (int k = 0; k < m2; k++)
          push_beat(p * m2 + k, k == 0, k == m2 - 1, 1'b1);
  endtask

  // leaves the caller at the negedge of pass cycle 0 (cyc == s)
  task automatic begin_pass(input int m1, input int m2, input int m3, output int s);
    done_cnt     = 0;
    first_en_cyc = -1;
    last_v_cyc   = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.m1dn1 = MW'(m1);
    bus.m2    = MW'(m2);
    bus.m3dn2 = MW'(m3);
    s = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic goto_cycle(input int s, input int c);
    while (cyc - s < c) @(negedge clk);
  endtask

  task automatic finish_pass(input int s, input int exp_done, input string name);
    int dc;
    dc = -1;
    for (int n = 0; n < 300; n++) begin
      if (bus.done) begin
        dc = cyc - s;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_done_cyc"}, dc, exp_done);
    chk({name, "_busy_at_done"}, longint'(bus.busy), 0);
    repeat (4) @(negedge clk);
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_rd_left"}, exp_rd.size(), 0);
    chk({name, "_v_left"}, exp_v.size(), 0);
    exp_rd.delete();
    exp_v.delete();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    beat_t e;
    if (bus.rd_en_b[0]) begin
      if (first_en_cyc < 0) first_en_cyc = cyc;
      if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        e = exp_rd.pop_front();
`ifdef MEM_READ_B_SKEW_EN
        chk("rd_addr_lane0", longint'(bus.rd_addr_b[0 +: AW]), e.addr);
`else
        chk("rd_en_lanes", longint'(bus.rd_en_b), longint'(ALL_EN));
        for (int j = 0; j < N2; j++)
          chk("rd_addr_lane", longint'(bus.rd_addr_b[j*AW +: AW]), e.addr);
`endif
      end
    end
    if (bus.valid_out) begin
      last_v_cyc = cyc;
      if (exp_v.size() == 0) chk("valid_unexpected", 1, 0);
      else begin
        e = exp_v.pop_front();
        chk("first_k", longint'(bus.first_k), longint'(e.first));
        chk("last_k", longint'(bus.last_k), longint'(e.last));
      end
    end
    if (bus.done) done_cnt++;
  end

  initial begin
    int s;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.m1dn1 = '0;
    bus.m2    = '0;
    bus.m3dn2 = '0;
    bus.ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", longint'(bus.rd_en_b), 0);
    chk("rst_rd_addr", longint'(bus.rd_addr_b), 0);
    chk("rst_valid", longint'(bus.valid_out), 0);
    chk("rst_first_k", longint'(bus.first_k), 0);
    chk("rst_last_k", longint'(bus.last_k), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_done", longint'(bus.done), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic pass: M1dN1=1, M2=3, M3dN2=2 -> addresses 0..5
    push_pass(1, 3, 2);
    begin_pass(1, 3, 2, s);
    chk("basic_busy_c0", longint'(bus.busy), 1);
    goto_cycle(s, 7);
    chk("basic_busy_c7", longint'(bus.busy), 1);
    finish_pass(s, 8 + OFF, "basic");
    chk("basic_first_en", first_en_cyc - s, 1);
    chk("basic_last_valid", last_v_cyc - s, 7);

    // two row-blocks; start and size changes mid-pass are ignored
    push_pass(2, 3, 2);
    begin_pass(2, 3, 2, s);
    goto_cycle(s, 2);
    bus.start = 1'b1;
    bus.m1dn1 = MW'(3);
    bus.m2    = MW'(1);
    bus.m3dn2 = MW'(1);
    goto_cycle(s, 3);
    bus.start = 1'b0;
    finish_pass(s, 14 + OFF, "m1x2");

    // ready low for two issue slots
    push_pass(1, 3, 2);
    begin_pass(1, 3, 2, s);
    goto_cycle(s, 3);
    bus.ready = 1'b0;
    goto_cycle(s, 4);
    chk("stall_en_c4", longint'(bus.rd_en_b[0]), 0);
    chk("stall_addr_hold", longint'(bus.rd_addr_b[0 +: AW]), 2);
    goto_cycle(s, 5);
    chk("stall_en_c5", longint'(bus.rd_en_b[0]), 0);
    bus.ready = 1'b1;
    finish_pass(s, 10 + OFF, "stall");

    // zero size: no issues, single done
    begin_pass(1, 0, 2, s);
    chk("zero_busy_c0", longint'(bus.busy), 1);
    finish_pass(s, 1, "zero");

    // reset mid-pass: beats at cycles 1..4 visible, valid at 2..4
    push_beat(0, 1'b1, 1'b0, 1'b1);
    push_beat(1, 1'b0, 1'b0, 1'b1);
    push_beat(2, 1'b0, 1'b1, 1'b1);
    push_beat(3, 1'b1, 1'b0, 1'b0);
    begin_pass(1, 3, 2, s);
    goto_cycle(s, 4);
    rst = 1'b1;
    goto_cycle(s, 5);
    chk("abort_rd_en", longint'(bus.rd_en_b), 0);
    chk("abort_rd_addr", longint'(bus.rd_addr_b), 0);
    chk("abort_valid", longint'(bus.valid_out), 0);
    chk("abort_busy", longint'(bus.busy), 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_rd_left", exp_rd.size(), 0);
    chk("abort_v_left", exp_v.size(), 0);
    exp_rd.delete();
    exp_v.delete();

    // clean pass after abort
    push_pass(1, 3, 2);
    begin_pass(1, 3, 2, s);
    finish_pass(s, 8 + OFF, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
